lcd_temp_display: RTL and testbench
===================================

# lcd_temp_display

Parametrised HD44780 character-LCD controller for 8-bit bus mode. It renders one or two signed 9-bit, half-degree temperature readings as formatted text. After reset it runs the init sequence once, then redraws the display on each `update` request; redraws readdress DDRAM instead of clearing, so the display does not flicker. It sits between the temperature-sensor readout logic and the LCD pins, and brings in signed values, a degree glyph, leading-zero blanking, an update handshake and optional second-line support.

## Interface
- `DIV`, 16: clk cycles per `lcd_en` phase; one LCD write takes 2*DIV cycles.
- `LINE_CHARS`, 16: characters written per line, minimum 8.
- `POR_WAIT`, 1000: clk cycles of idle after reset before the first command.
- `CLEAR_WAIT`, 2000: clk cycles of idle after the clear command (0x01).
- `clk`, input, 1: system clock; all logic on posedge.
- `rst_n`, input, 1: synchronous active-low reset.
- `temp_a`, input, 16: channel A reading; [15:7] two's complement in 0.5 °C units; [6:0] ignored.
- `temp_b`, input, 16: channel B reading, same format; used only with the dual-line configuration.
- `update`, input, 1: redraw request; a single-cycle pulse or a held level are both accepted.
- `busy`, output, 1: high during init and while a redraw is in progress.
- `lcd_rs`, output, 1: 0 = command, 1 = data.
- `lcd_rw`, output, 1: tied to 0.
- `lcd_en`, output, 1: LCD enable strobe.
- `lcd_data`, output, 8: LCD data bus.

## Operation
- **Reset values:** `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `busy`=1, pending flag = 0, state = POR.
  - `rst_n` low at any point aborts immediately to these values, including mid-write with `lcd_en` high.
- **States:** POR → INIT → CLRW → IDLE → CONV → ADDR → CHAR, then either back to ADDR for line 2 or to IDLE.
- **POR:** waits POR_WAIT cycles.
- **INIT:** issues four commands: function set (FS), 0x0C, 0x06, 0x01.
  - FS = 0x38 with the dual-line macro, 0x30 without it.
- **CLRW:** waits CLEAR_WAIT cycles after the 0x01 write completes, then enters IDLE with `busy`=0.
- **IDLE:** `update` high → snapshot `temp_a`/`temp_b` into registers and enter CONV.
- **CONV:** computes the magnitude of each channel.
  - Sign is v[8]; mag = sign ? −v : v over 9 bits; int = mag[8:1] (0..128); frac = mag[0].
  - Converts int to 3 BCD digits with a sequential double-dabble, 8 shift cycles plus 2 setup/finish cycles = exactly 10 cycles; both channels convert in parallel.
- **ADDR:** writes command 0x80 for line 1 and 0xC0 for line 2.
- **CHAR:** writes LINE_CHARS data bytes; columns are 0-based.
  - Col 0: '-' if negative, else ' '.
  - Col 1: hundreds digit, or ' ' if 0.
  - Col 2: tens digit, or ' ' if hundreds and tens are both 0.
  - Col 3: units digit.
  - Col 4: '.'.
  - Col 5: '5' if frac, else '0'.
  - Col 6: 0xDF (degree glyph).
  - Col 7: 'C'.
  - Cols 8..LINE_CHARS−1: ' '.
  - Digits are ASCII 0x30+d.
- **Channel order:** line 1 is channel A; line 2 is channel B.
- **Update during a redraw:** `update` while `busy` sets a one-deep pending flag; extra requests are merged into it.
  - When the current frame ends, a set pending flag clears and starts a new redraw from a fresh snapshot with no IDLE cycle. `busy` stays high throughout.
- **Update during init:** `update` during POR/INIT/CLRW is also held pending and is serviced on entry to IDLE.
- **Input changes:** `temp_a`/`temp_b` changing after the snapshot do not affect the frame in progress.

## Timing
- **Write cycle:** `lcd_rs`/`lcd_data` become valid on cycle 0 of a write and stay stable for all 2*DIV cycles.
  - `lcd_en`=1 for cycles 0..DIV−1 and 0 for cycles DIV..2*DIV−1.
  - Writes are back-to-back with no gap.
- **Update latency:** `update` sampled high in IDLE at edge t.
  - `busy`=1 from t+1.
  - CONV occupies t+1..t+10.
  - The first `lcd_en` rise (address command) is at t+11.
- **Frame length:** W = 1+LINE_CHARS writes for single-line, 2*(1+LINE_CHARS) for dual-line.
  - `busy` falls on the cycle after the last write's low phase ends: t+11+W*2*DIV.
- **Init length:** POR_WAIT + 4*2*DIV + CLEAR_WAIT cycles from reset release to `busy`=0.
- **Width rules:** −v is computed in 9 bits. The −256 code (0x100) yields mag 256 and must display as "-128.0"; the hundreds digit never exceeds 1.

## Configuration
- **With `LCD_DUAL_LINE_EN` defined:**
  - FS = 0x38.
  - Each frame writes line 1 (0x80 + A) then line 2 (0xC0 + B).
- **Without `LCD_DUAL_LINE_EN`:**
  - FS = 0x30.
  - `temp_b` is unused and no 0xC0 command is ever issued.
  - Frame = 1+LINE_CHARS writes.

## Test plan
All scenarios use DIV=2, LINE_CHARS=16, POR_WAIT=20 and CLEAR_WAIT=40 unless noted.
- **Reset/init:** release `rst_n`.
  - Outputs are at reset values; after 20 cycles the bytes 0x38, 0x0C, 0x06, 0x01 appear with rs=0 and each `lcd_en` high pulse is 2 cycles.
  - `busy` falls exactly 20+16+40 cycles after release.
- **Positive value:** `temp_a`=0x1980, pulse `update`.
  - First `lcd_en` rise after 11 cycles with 0x80, rs=0.
  - Then rs=1 bytes ' ',' ','2','5','.','5',0xDF,'C' followed by 8 spaces.
- **Negative, boundary and blanking values:**
  - `temp_a`=0xE700 → "-", ' ', '2', '5', '.', '0'.
  - `temp_a`=0x7D00 → ' ', '1', '2', '5', '.', '0'.
  - `temp_a`=0xFF80 → '-', ' ', ' ', '0', '.', '5'.
  - `temp_a`=0x8000 → '-', '1', '2', '8', '.', '0'.
- **Dual line (`LCD_DUAL_LINE_EN`):** `temp_a`=0x1980, `temp_b`=0xE700.
  - FS=0x38; the frame is 0x80 + line A, then 0xC0 + line B.
  - `busy` is high for 10+34*4 cycles.
- **Pending update:** pulse `update` twice during a frame and change `temp_a` to 0x0000 mid-frame.
  - The current frame keeps its old text.
  - Exactly one extra frame starts with no `busy` low cycle and shows ' ',' ',' ','0','.','0'.
- **Mid-write reset:** assert `rst_n`=0 while `lcd_en`=1.
  - Next edge: `lcd_en`=0, `lcd_data`=0x00, `busy`=1.
  - The full init sequence repeats after release.

Source files
------------

// File: rtl/lcd_temp_display_if.sv
// Request/LCD-pin bundle for lcd_temp_display.
// master: sensor-side producer (drives readings and update, observes LCD pins).
// slave:  the controller itself.
interface lcd_temp_display_if;
   logic [15:0] temp_a;
   logic [15:0] temp_b;
   logic        update;
   logic        busy;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_en;
   logic [7:0]  lcd_data;

   modport master (
      output temp_a, temp_b, update,
      input  busy, lcd_rs, lcd_rw, lcd_en, lcd_data
   );

   modport slave (
      input  temp_a, temp_b, update,
      output busy, lcd_rs, lcd_rw, lcd_en, lcd_data
   );
endinterface

// File: rtl/lcd_temp_display.sv
// HD44780 8-bit-bus controller rendering one (or two) signed half-degree
// temperature readings as "-128.5<deg>C" style text.
// Optional feature macro: LCD_DUAL_LINE_EN (two-line mode, channel B on line 2).
module lcd_temp_display #(
   parameter int DIV        = 16,
   parameter int LINE_CHARS = 16,
   parameter int POR_WAIT   = 1000,
   parameter int CLEAR_WAIT = 2000
) (
   input logic               clk,
   input logic               rst_n,
   lcd_temp_display_if.slave bus
);

`ifdef LCD_DUAL_LINE_EN
   localparam logic [7:0] FS_CMD = 8'h38;
`else
   localparam logic [7:0] FS_CMD = 8'h30;
`endif

   typedef enum logic [2:0] {
      S_POR, S_INIT, S_CLRW, S_IDLE, S_CONV, S_ADDR, S_CHAR
   } state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [15:0] wcnt;
   logic [15:0] col;
   logic [1:0]  idx;
   logic        pending;
   logic        busy_r;
   logic        en_r;
   logic        rs_r;
   logic [7:0]  data_r;

   // Channel A: snapshot, double-dabble register {hund,tens,units,bin}, sign, half bit
   logic [8:0]  snap_a;
   logic [8:0]  mag_a;
   logic [19:0] dd_a;
   logic        neg_a;
   logic        frac_a;
`ifdef LCD_DUAL_LINE_EN
   logic [8:0]  snap_b;
   logic [8:0]  mag_b;
   logic [19:0] dd_b;
   logic        neg_b;
   logic        frac_b;
   logic        line;
`endif

   logic        sel_neg;
   logic [11:0] sel_bcd;
   logic        sel_frac;
   logic        unused_bits;

   assign bus.busy     = busy_r;
   assign bus.lcd_en   = en_r;
   assign bus.lcd_rs   = rs_r;
   assign bus.lcd_rw   = 1'b0;
   assign bus.lcd_data = data_r;

`ifdef LCD_DUAL_LINE_EN
   assign unused_bits = ^{bus.temp_a[6:0], bus.temp_b[6:0]};
`else
   assign unused_bits = ^{bus.temp_a[6:0], bus.temp_b};
`endif

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return FS_CMD;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   function automatic logic [19:0] dabble(input logic [19:0] s);
      logic [19:0] r;
      r = s;
      for (int unsigned i = 0; i < 3; i++) begin
         if (r[8 + 4*i +: 4] >= 4'd5) r[8 + 4*i +: 4] = r[8 + 4*i +: 4] + 4'd3;
      end
      return {r[18:0], 1'b0};
   endfunction

   function automatic logic [7:0] glyph(input logic [15:0] c, input logic neg,
                                        input logic [11:0] bcd, input logic frac);
      case (c)
         16'd0:   return neg ? 8'h2D : 8'h20;
         16'd1:   return (bcd[11:8] == 4'd0) ? 8'h20 : {4'h3, bcd[11:8]};
         16'd2:   return (bcd[11:4] == 8'd0) ? 8'h20 : {4'h3, bcd[7:4]};
         16'd3:   return {4'h3, bcd[3:0]};
         16'd4:   return 8'h2E;
         16'd5:   return frac ? 8'h35 : 8'h30;
         16'd6:   return 8'hDF;
         16'd7:   return 8'h43;
         default: return 8'h20;
      endcase
   endfunction

   // Magnitudes (9-bit negate, so 0x100 stays 256) and per-line glyph source select
   always_comb begin
      mag_a    = snap_a[8] ? (~snap_a + 9'd1) : snap_a;
      sel_neg  = neg_a;
      sel_bcd  = dd_a[19:8];
      sel_frac = frac_a;
`ifdef LCD_DUAL_LINE_EN
      mag_b = snap_b[8] ? (~snap_b + 9'd1) : snap_b;
      if (line) begin
         sel_neg  = neg_b;
         sel_bcd  = dd_b[19:8];
         sel_frac = frac_b;
      end
`endif
   end

   task automatic start_write(input logic rs, input logic [7:0] d);
      en_r   <= 1'b1;
      rs_r   <= rs;
      data_r <= d;
      wcnt   <= '0;
   endtask

   // Snapshot inputs and begin a frame; used from IDLE and on pending back-to-back redraw
   task automatic take_snapshot();
      snap_a  <= bus.temp_a[15:7];
`ifdef LCD_DUAL_LINE_EN
      snap_b  <= bus.temp_b[15:7];
      line    <= 1'b0;
`endif
      pending <= 1'b0;
      busy_r  <= 1'b1;
      cnt     <= '0;
      state   <= S_CONV;
   endtask

   // Main controller: init sequence, conversion, and the LCD write engine
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_POR;
         cnt     <= '0;
         wcnt    <= '0;
         col     <= '0;
         idx     <= '0;
         pending <= 1'b0;
         busy_r  <= 1'b1;
         en_r    <= 1'b0;
         rs_r    <= 1'b0;
         data_r  <= '0;
         snap_a  <= '0;
         dd_a    <= '0;
         neg_a   <= 1'b0;
         frac_a  <= 1'b0;
`ifdef LCD_DUAL_LINE_EN
         snap_b  <= '0;
         dd_b    <= '0;
         neg_b   <= 1'b0;
         frac_b  <= 1'b0;
         line    <= 1'b0;
`endif
      end else begin
         // Requests outside IDLE merge into one pending redraw; consumers clear it below
         if (bus.update) pending <= 1'b1;
         case (state)
            S_POR: begin
               if (cnt == 32'(POR_WAIT)) begin
                  idx   <= '0;
                  state <= S_INIT;
                  start_write(1'b0, FS_CMD);
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_CLRW: begin
               if (cnt == 32'(CLEAR_WAIT - 1)) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_IDLE: begin
               if (bus.update || pending) take_snapshot();
            end
            S_CONV: begin
               // cnt 0: load, 1..8: shift, 9: digits final, issue line-1 address
               cnt <= cnt + 32'd1;
               if (cnt == 32'd0) begin
                  dd_a   <= {12'd0, mag_a[8:1]};
                  neg_a  <= snap_a[8];
                  frac_a <= mag_a[0];
`ifdef LCD_DUAL_LINE_EN
                  dd_b   <= {12'd0, mag_b[8:1]};
                  neg_b  <= snap_b[8];
                  frac_b <= mag_b[0];
`endif
               end else if (cnt == 32'd9) begin
                  state <= S_ADDR;
                  start_write(1'b0, 8'h80);
               end else begin
                  dd_a <= dabble(dd_a);
`ifdef LCD_DUAL_LINE_EN
                  dd_b <= dabble(dd_b);
`endif
               end
            end
            S_INIT, S_ADDR, S_CHAR: begin
               wcnt <= wcnt + 16'd1;
               if (wcnt == 16'(DIV - 1)) en_r <= 1'b0;
               if (wcnt == 16'(2*DIV - 1)) begin
                  if (state == S_INIT) begin
                     if (idx == 2'd3) begin
                        cnt   <= '0;
                        state <= S_CLRW;
                     end else begin
                        idx <= idx + 2'd1;
                        start_write(1'b0, init_cmd(idx + 2'd1));
                     end
                  end else if (state == S_ADDR) begin
                     col   <= '0;
                     state <= S_CHAR;
                     start_write(1'b1, glyph(16'd0, sel_neg, sel_bcd, sel_frac));
                  end else if (col != 16'(LINE_CHARS - 1)) begin
                     col <= col + 16'd1;
                     start_write(1'b1, glyph(col + 16'd1, sel_neg, sel_bcd, sel_frac));
                  end
`ifdef LCD_DUAL_LINE_EN
                  else if (!line) begin
                     line  <= 1'b1;
                     state <= S_ADDR;
                     start_write(1'b0, 8'hC0);
                  end
`endif
                  else if (pending || bus.update) begin
                     take_snapshot();
                  end else begin
                     state  <= S_IDLE;
                     busy_r <= 1'b0;
                  end
               end
            end
            default: state <= S_POR;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_temp_display.sv
// Self-checking bench for lcd_temp_display; adapts to LCD_DUAL_LINE_EN.
module tb_lcd_temp_display;
   localparam int DIV = 2;
   localparam int LC  = 16;
   localparam int PW  = 20;
   localparam int CW  = 40;
`ifdef LCD_DUAL_LINE_EN
   localparam bit         DUAL = 1'b1;
   localparam logic [7:0] FS   = 8'h38;
`else
   localparam bit         DUAL = 1'b0;
   localparam logic [7:0] FS   = 8'h30;
`endif
   localparam int W     = DUAL ? 2*(1+LC) : 1+LC;
   localparam int FRAME = 10 + W*2*DIV;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lcd_temp_display_if bus();

   lcd_temp_display #(.DIV(DIV), .LINE_CHARS(LC), .POR_WAIT(PW), .CLEAR_WAIT(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct { logic rs; logic [7:0] data; int cyc; } wr_t;
   wr_t        wq[$];
   logic [8:0] exp_q[$];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int unstable = 0, hi_bad = 0, rw_bad = 0, early = 0;

   // Bus monitor: records every write (rising lcd_en) and tracks protocol violations
   int         m_start = 0, m_hi = 0;
   bit         m_in = 1'b0;
   logic       m_prev = 1'b0, m_rs = 1'b0;
   logic [7:0] m_data = '0;
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst_n) begin
         m_in = 1'b0;
      end else begin
         if (bus.lcd_en && !m_prev) begin
            if (m_in) early++;
            wq.push_back('{bus.lcd_rs, bus.lcd_data, cyc});
            m_in = 1'b1; m_start = cyc; m_hi = 1;
            m_rs = bus.lcd_rs; m_data = bus.lcd_data;
         end else if (m_in) begin
            if (bus.lcd_en) m_hi++;
            if (bus.lcd_rs !== m_rs || bus.lcd_data !== m_data) unstable++;
            if (cyc - m_start == 2*DIV - 1) begin
               if (m_hi != DIV) hi_bad++;
               m_in = 1'b0;
            end
         end
         if (bus.lcd_rw !== 1'b0) rw_bad++;
      end
      m_prev = bus.lcd_en;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference text: plain integer arithmetic on the half-degree value
   function automatic logic [7:0] model_char(input logic [15:0] t, input int c);
      int v, m, ip;
      v  = int'($signed(t[15:7]));
      m  = (v < 0) ? -v : v;
      ip = m / 2;
      case (c)
         0:       return (v < 0) ? 8'h2D : 8'h20;
         1:       return (ip >= 100) ? 8'h30 + 8'(ip / 100) : 8'h20;
         2:       return (ip >= 10) ? 8'h30 + 8'((ip / 10) % 10) : 8'h20;
         3:       return 8'h30 + 8'(ip % 10);
         4:       return 8'h2E;
         5:       return (m % 2 == 1) ? 8'h35 : 8'h30;
         6:       return 8'hDF;
         7:       return 8'h43;
         default: return 8'h20;
      endcase
   endfunction

   task automatic add_expected(input logic [15:0] a, input logic [15:0] b);
      exp_q.push_back({1'b0, 8'h80});
      for (int c = 0; c < LC; c++) exp_q.push_back({1'b1, model_char(a, c)});
      if (DUAL) begin
         exp_q.push_back({1'b0, 8'hC0});
         for (int c = 0; c < LC; c++) exp_q.push_back({1'b1, model_char(b, c)});
      end
   endtask

   task automatic do_update(input logic [15:0] a, input logic [15:0] b,
                            output int t, output int fall, output bit timeout);
      bus.temp_a = a;
      bus.temp_b = b;
      bus.update = 1'b1;
      tick();
      t = cyc;
      bus.update = 1'b0;
      timeout = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (!bus.busy) begin
            timeout = 1'b0;
            break;
         end
         tick();
      end
      fall = cyc;
   endtask

   task automatic test_reset();
      int r;
      bit done;
      logic [7:0] cmds [4];
      cmds[0] = FS; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
      rst_n = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.busy} !== {3'b000, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_values: got en=%b rs=%b rw=%b data=%h busy=%b, want en=0 rs=0 rw=0 data=00 busy=1",
                  bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.busy);
      end
      wq = {};
      rst_n = 1'b1;
      r = cyc + 1;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!bus.busy) begin
            done = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!done || cyc - r != PW + 4*2*DIV + CW) begin
         n_fail++;
         $display("FAIL init_length: got %0d cycles (done=%0b), want %0d", cyc - r, done, PW + 4*2*DIV + CW);
      end
      n_tests++;
      if (wq.size() != 4) begin
         n_fail++;
         $display("FAIL init_write_count: got %0d, want 4", wq.size());
      end
      for (int i = 0; i < 4 && i < wq.size(); i++) begin
         n_tests++;
         if ({wq[i].rs, wq[i].data} !== {1'b0, cmds[i]}) begin
            n_fail++;
            $display("FAIL init_cmd[%0d]: got rs=%b data=%h, want rs=0 data=%h", i, wq[i].rs, wq[i].data, cmds[i]);
         end
      end
      if (wq.size() > 0) begin
         n_tests++;
         if (wq[0].cyc - r != PW) begin
            n_fail++;
            $display("FAIL por_wait: first command after %0d cycles, want %0d", wq[0].cyc - r, PW);
         end
      end
   endtask

   task automatic test_values();
      logic [15:0] vals [$];
      logic [15:0] b;
      int t, fall;
      bit to;
      vals = '{16'h1980, 16'hE700, 16'h7D00, 16'hFF80, 16'h8000, 16'h0000, 16'h00FF};
      for (int k = 0; k < 6; k++) vals.push_back(16'($urandom));
      foreach (vals[k]) begin
         b = 16'($urandom);
         if (k == 0) b = 16'hE700;
         tick();
         wq = {};
         exp_q = {};
         add_expected(vals[k], b);
         do_update(vals[k], b, t, fall, to);
         n_tests++;
         if (to || fall - t != FRAME) begin
            n_fail++;
            $display("FAIL busy_len a=%h: got %0d (timeout=%0b), want %0d", vals[k], fall - t, to, FRAME);
         end
         n_tests++;
         if (wq.size() != W) begin
            n_fail++;
            $display("FAIL write_count a=%h: got %0d, want %0d", vals[k], wq.size(), W);
         end
         if (wq.size() > 0) begin
            n_tests++;
            if (wq[0].cyc - t != 10) begin
               n_fail++;
               $display("FAIL first_en_latency a=%h: got %0d, want 10", vals[k], wq[0].cyc - t);
            end
         end
         for (int i = 0; i < W && i < wq.size(); i++) begin
            n_tests++;
            if ({wq[i].rs, wq[i].data} !== exp_q[i] || wq[i].cyc - wq[0].cyc != i*2*DIV) begin
               n_fail++;
               $display("FAIL byte[%0d] a=%h b=%h: got rs=%b data=%h off=%0d, want rs=%b data=%h off=%0d",
                        i, vals[k], b, wq[i].rs, wq[i].data, wq[i].cyc - wq[0].cyc,
                        exp_q[i][8], exp_q[i][7:0], i*2*DIV);
            end
         end
      end
   endtask

   task automatic test_pending();
      logic [15:0] a0, b;
      int t;
      bit done;
      a0 = {8'($urandom_range(1, 250)), 8'($urandom)};
      b  = 16'($urandom);
      tick();
      wq = {};
      exp_q = {};
      add_expected(a0, b);
      add_expected(16'h0000, b);
      bus.temp_a = a0;
      bus.temp_b = b;
      bus.update = 1'b1;
      tick();
      t = cyc;
      bus.update = 1'b0;
      repeat (20) tick();
      bus.update = 1'b1;
      tick();
      bus.update = 1'b0;
      bus.temp_a = 16'h0000;
      repeat (15) tick();
      bus.update = 1'b1;
      tick();
      bus.update = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!bus.busy) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      n_tests++;
      if (!done || cyc - t != 2*FRAME) begin
         n_fail++;
         $display("FAIL pending_busy_len: got %0d (done=%0b), want %0d", cyc - t, done, 2*FRAME);
      end
      repeat (100) tick();
      n_tests++;
      if (wq.size() != 2*W) begin
         n_fail++;
         $display("FAIL pending_write_count: got %0d, want %0d", wq.size(), 2*W);
      end
      if (wq.size() > W) begin
         n_tests++;
         if (wq[W].cyc - t != FRAME + 10) begin
            n_fail++;
            $display("FAIL pending_restart: second frame at %0d, want %0d", wq[W].cyc - t, FRAME + 10);
         end
      end
      for (int i = 0; i < 2*W && i < wq.size(); i++) begin
         n_tests++;
         if ({wq[i].rs, wq[i].data} !== exp_q[i]) begin
            n_fail++;
            $display("FAIL pending_byte[%0d] a0=%h: got rs=%b data=%h, want rs=%b data=%h",
                     i, a0, wq[i].rs, wq[i].data, exp_q[i][8], exp_q[i][7:0]);
         end
      end
   endtask

   task automatic test_midwrite_reset();
      bit seen;
      tick();
      bus.temp_a = 16'h1980;
      bus.update = 1'b1;
      tick();
      bus.update = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.lcd_en) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL midwrite_en_seen: got en=0 within 200 cycles, want en=1");
      end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if ({bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.busy} !== {2'b00, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL midwrite_reset: got en=%b rs=%b data=%h busy=%b, want en=0 rs=0 data=00 busy=1",
                  bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.busy);
      end
      test_reset();
   endtask

   task automatic test_bus_integrity();
      n_tests++;
      if (unstable != 0 || hi_bad != 0 || rw_bad != 0 || early != 0) begin
         n_fail++;
         $display("FAIL bus_protocol: got unstable=%0d hi_bad=%0d rw_bad=%0d early=%0d, want all 0",
                  unstable, hi_bad, rw_bad, early);
      end
   endtask

   initial begin
      bus.temp_a = '0;
      bus.temp_b = '0;
      bus.update = 1'b0;
      test_reset();
      test_values();
      test_pending();
      test_midwrite_reset();
      test_bus_integrity();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
